// File: rtl/an_capture.sv
// an_capture
// Receiving end of a multiplexed 4-digit display link. The driver strobes
// active-low anodes an3..an0 in that order, one at a time, while presenting
// the digit code on the shared char bus. This block registers the pins once,
// follows the strobe sequence with a small FSM, collects one shadow digit per
// anode window and commits all four digits at once when the an0 window ends.
//
// Ports:
//   clk             system clock, all logic on the rising edge
//   SYNC_DEBNC_RST  asynchronous active-high reset
//   an0..an3        anode strobes, active low
//   char[3:0]       shared digit code
//   err_clr         synchronous clear of the sticky error flags
//   digit0..digit3  last committed frame
//   frame_valid     one-cycle pulse on commit
//   scroll_step     one-cycle pulse with frame_valid when every digit stepped
//                   down by one (mod 16) from the previous frame
//   frame_count     committed-frame counter, wraps
//   order_err, multi_err, glitch_err, width_err, timeout_err  sticky flags
//   state_dbg       current FSM state, for monitors and checkers
//
// Handshake: there is no back-pressure. frame_valid is a single-cycle
// qualifier for digit0..digit3, scroll_step and frame_count; the digits stay
// stable until the next commit or reset.
module an_capture #(
  parameter int TIMEOUT_WIDTH   = 10,
  parameter int TIMEOUT         = 64,
  parameter int MIN_ON          = 1,
  parameter int FRAME_CNT_WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       SYNC_DEBNC_RST,
  input  logic                       an0,
  input  logic                       an1,
  input  logic                       an2,
  input  logic                       an3,
  input  logic [3:0]                 char,
  input  logic                       err_clr,
  output logic [3:0]                 digit0,
  output logic [3:0]                 digit1,
  output logic [3:0]                 digit2,
  output logic [3:0]                 digit3,
  output logic                       frame_valid,
  output logic                       scroll_step,
  output logic [FRAME_CNT_WIDTH-1:0] frame_count,
  output logic                       order_err,
  output logic                       multi_err,
  output logic                       glitch_err,
  output logic                       width_err,
  output logic                       timeout_err,
  output logic [2:0]                 state_dbg
);

  localparam int WW = (MIN_ON < 2) ? 1 : $clog2(MIN_ON + 1);
  localparam logic [WW-1:0]            MIN_ON_W   = WW'(MIN_ON);
  localparam logic [TIMEOUT_WIDTH-1:0] TIMEOUT_W  = TIMEOUT_WIDTH'(TIMEOUT);
  localparam logic [TIMEOUT_WIDTH-1:0] TIMEOUT_M1 = TIMEOUT_WIDTH'(TIMEOUT - 1);

  // Encoding is deliberate: bits [2:1] give (3 - digit index) and bit 0 says
  // "inside the anode window", so WAIT_Dk -> ON_Dk and ON_Dk -> WAIT_D(k-1)
  // are both state + 1.
  typedef enum logic [2:0] {
    WAIT_D3 = 3'd0,
    ON_D3   = 3'd1,
    WAIT_D2 = 3'd2,
    ON_D2   = 3'd3,
    WAIT_D1 = 3'd4,
    ON_D1   = 3'd5,
    WAIT_D0 = 3'd6,
    ON_D0   = 3'd7
  } state_t;

  state_t                     state_q, state_d;
  logic [3:0]                 an_q, an_d;
  logic [3:0]                 char_q, char_d;
  logic [3:0][3:0]            shadow_q, shadow_d;
  logic [3:0][3:0]            digit_q, digit_d;
  logic [WW-1:0]              width_q, width_d;
  logic [TIMEOUT_WIDTH-1:0]   gap_q, gap_d;
  logic [FRAME_CNT_WIDTH-1:0] frame_count_q, frame_count_d;
  logic                       first_frame_q, first_frame_d;
  logic                       frame_valid_q, frame_valid_d;
  logic                       scroll_step_q, scroll_step_d;
  logic                       order_err_q, order_err_d;
  logic                       multi_err_q, multi_err_d;
  logic                       glitch_err_q, glitch_err_d;
  logic                       width_err_q, width_err_d;
  logic                       timeout_err_q, timeout_err_d;

  logic [3:0] low;
  logic       any_low;
  logic       multi_low;
  logic [1:0] low_idx;
  logic [1:0] cur_k;
  logic       in_window;
  logic       timeout_hit;
  logic       step_ok;
  logic       set_order, set_multi, set_glitch, set_width, set_timeout;

  always_comb begin
    an_d          = {an3, an2, an1, an0};
    char_d        = char;
    state_d       = state_q;
    shadow_d      = shadow_q;
    digit_d       = digit_q;
    width_d       = width_q;
    gap_d         = gap_q;
    frame_count_d = frame_count_q;
    first_frame_d = first_frame_q;
    frame_valid_d = 1'b0;
    scroll_step_d = 1'b0;
    set_order     = 1'b0;
    set_multi     = 1'b0;
    set_glitch    = 1'b0;
    set_width     = 1'b0;
    set_timeout   = 1'b0;

    low       = ~an_q;
    any_low   = |low;
    // Clearing the lowest set bit leaves something only if two or more are low.
    multi_low = (low & (low - 4'd1)) != 4'd0;
    case (low)
      4'b0010: low_idx = 2'd1;
      4'b0100: low_idx = 2'd2;
      4'b1000: low_idx = 2'd3;
      default: low_idx = 2'd0;
    endcase
    cur_k       = 2'd3 - state_q[2:1];
    in_window   = state_q[0];
    timeout_hit = !any_low && (gap_q == TIMEOUT_M1);

    // Compared against the digits still on the outputs, i.e. pre-commit.
    step_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (shadow_q[i] != digit_q[i] - 4'd1) step_ok = 1'b0;
    end

    if (any_low) begin
      gap_d = '0;
    end else if (gap_q != TIMEOUT_W) begin
      gap_d = gap_q + 1'b1;
    end

    if (multi_low) begin
      set_multi = 1'b1;
      state_d   = WAIT_D3;
    end else if (timeout_hit) begin
      set_timeout = 1'b1;
      state_d     = WAIT_D3;
    end else if (!in_window) begin
      if (any_low) begin
        if (low_idx == cur_k) begin
          state_d          = state_t'(state_q + 3'd1);
          shadow_d[cur_k]  = char_q;
          width_d          = WW'(1);
        end else begin
          set_order = 1'b1;
          if (low_idx == 2'd3) begin
            // an3 out of turn is taken as the start of a new frame.
            state_d     = ON_D3;
            shadow_d[3] = char_q;
            width_d     = WW'(1);
          end else begin
            state_d = WAIT_D3;
          end
        end
      end
    end else begin
      if (low[cur_k]) begin
        if (width_q < MIN_ON_W) width_d = width_q + 1'b1;
        if (char_q != shadow_q[cur_k]) set_glitch = 1'b1;
      end else if (width_q >= MIN_ON_W) begin
        if (cur_k == 2'd0) begin
          digit_d       = shadow_q;
          frame_valid_d = 1'b1;
          scroll_step_d = step_ok & ~first_frame_q;
          first_frame_d = 1'b0;
          frame_count_d = frame_count_q + 1'b1;
          state_d       = WAIT_D3;
        end else begin
          state_d = state_t'(state_q + 3'd1);
        end
      end else begin
        set_width = 1'b1;
        state_d   = WAIT_D3;
      end
    end

    // A set event in the same cycle as err_clr keeps the flag set.
    order_err_d   = set_order   | (order_err_q   & ~err_clr);
    multi_err_d   = set_multi   | (multi_err_q   & ~err_clr);
    glitch_err_d  = set_glitch  | (glitch_err_q  & ~err_clr);
    width_err_d   = set_width   | (width_err_q   & ~err_clr);
    timeout_err_d = set_timeout | (timeout_err_q & ~err_clr);
  end

  always_ff @(posedge clk or posedge SYNC_DEBNC_RST) begin
    if (SYNC_DEBNC_RST) begin
      state_q       <= WAIT_D3;
      an_q          <= 4'hF;
      char_q        <= 4'h0;
      shadow_q      <= '0;
      digit_q       <= '0;
      width_q       <= '0;
      gap_q         <= '0;
      frame_count_q <= '0;
      first_frame_q <= 1'b1;
      frame_valid_q <= 1'b0;
      scroll_step_q <= 1'b0;
      order_err_q   <= 1'b0;
      multi_err_q   <= 1'b0;
      glitch_err_q  <= 1'b0;
      width_err_q   <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      an_q          <= an_d;
      char_q        <= char_d;
      shadow_q      <= shadow_d;
      digit_q       <= digit_d;
      width_q       <= width_d;
      gap_q         <= gap_d;
      frame_count_q <= frame_count_d;
      first_frame_q <= first_frame_d;
      frame_valid_q <= frame_valid_d;
      scroll_step_q <= scroll_step_d;
      order_err_q   <= order_err_d;
      multi_err_q   <= multi_err_d;
      glitch_err_q  <= glitch_err_d;
      width_err_q   <= width_err_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign digit0      = digit_q[0];
  assign digit1      = digit_q[1];
  assign digit2      = digit_q[2];
  assign digit3      = digit_q[3];
  assign frame_valid = frame_valid_q;
  assign scroll_step = scroll_step_q;
  assign frame_count = frame_count_q;
  assign order_err   = order_err_q;
  assign multi_err   = multi_err_q;
  assign glitch_err  = glitch_err_q;
  assign width_err   = width_err_q;
  assign timeout_err = timeout_err_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_an_capture.sv
// Testbench for an_capture. Drives anode windows and gaps at the pins and
// predicts committed frames and sticky flags from the link rules: frames are
// an3, an2, an1, an0 windows of at least MIN_ON cycles, digits commit on the
// end of the an0 window, scroll_step compares against the previous frame.
module tb_an_capture;
  localparam int TW      = 10;
  localparam int TIMEOUT = 64;
  localparam int MIN_ON  = 2;
  localparam int FCW     = 8;

  // ---------------- clock / reset / DUT ----------------
  logic           clk = 1'b0;
  logic           rst;
  logic [3:0]     an_drv;
  logic [3:0]     ch;
  logic           err_clr;
  logic [3:0]     digit0, digit1, digit2, digit3;
  logic           frame_valid, scroll_step;
  logic [FCW-1:0] frame_count;
  logic           order_err, multi_err, glitch_err, width_err, timeout_err;
  logic [2:0]     state_dbg;

  always #5 clk = ~clk;

  an_capture #(
    .TIMEOUT_WIDTH(TW), .TIMEOUT(TIMEOUT), .MIN_ON(MIN_ON), .FRAME_CNT_WIDTH(FCW)
  ) dut (
    .clk(clk), .SYNC_DEBNC_RST(rst),
    .an0(an_drv[0]), .an1(an_drv[1]), .an2(an_drv[2]), .an3(an_drv[3]),
    .char(ch), .err_clr(err_clr),
    .digit0(digit0), .digit1(digit1), .digit2(digit2), .digit3(digit3),
    .frame_valid(frame_valid), .scroll_step(scroll_step), .frame_count(frame_count),
    .order_err(order_err), .multi_err(multi_err), .glitch_err(glitch_err),
    .width_err(width_err), .timeout_err(timeout_err), .state_dbg(state_dbg)
  );

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [24:0] exp_q[$];   // {d3,d2,d1,d0,scroll,count}
  logic last_scroll = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // ---------------- reference model ----------------
  int         m_next;
  logic [3:0] m_shadow[4];
  logic [3:0] m_dig[4];
  bit         m_first;
  logic [7:0] m_count;
  bit         m_order, m_multi, m_glitch, m_width, m_timeout;
  int         m_gap;

  function automatic void model_reset();
    m_next = 3; m_first = 1'b1; m_count = 8'd0; m_gap = 0;
    m_order = 0; m_multi = 0; m_glitch = 0; m_width = 0; m_timeout = 0;
    for (int i = 0; i < 4; i++) begin m_shadow[i] = 4'd0; m_dig[i] = 4'd0; end
    exp_q.delete();
  endfunction

  function automatic void model_commit();
    bit down;
    down = !m_first;
    for (int i = 0; i < 4; i++) if (m_shadow[i] != 4'(m_dig[i] - 4'd1)) down = 1'b0;
    for (int i = 0; i < 4; i++) m_dig[i] = m_shadow[i];
    m_count = m_count + 8'd1;
    m_first = 1'b0;
    exp_q.push_back({m_dig[3], m_dig[2], m_dig[1], m_dig[0], down, m_count});
  endfunction

  function automatic void model_window(input int k, input int len, input logic [3:0] c0,
                                       input bit glitchy);
    m_gap = 0;
    if (k != m_next) begin
      m_order = 1'b1;
      if (k != 3) begin m_next = 3; return; end
    end
    m_shadow[k] = c0;
    if (glitchy && len > 1) m_glitch = 1'b1;
    if (len < MIN_ON) begin m_width = 1'b1; m_next = 3; end
    else if (k == 0) begin model_commit(); m_next = 3; end
    else m_next = k - 1;
  endfunction

  function automatic void model_gap(input int n);
    if (m_gap < TIMEOUT && m_gap + n >= TIMEOUT) begin m_timeout = 1'b1; m_next = 3; end
    m_gap = m_gap + n;
    if (m_gap > TIMEOUT) m_gap = TIMEOUT;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step(input logic [3:0] an, input logic [3:0] c);
    an_drv = an; ch = c;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(4'hF, 4'($urandom));
    model_gap(n);
  endtask

  task automatic window(input int k, input int len, input logic [3:0] c0, input bit glitchy);
    logic [3:0] a;
    a = 4'hF; a[k[1:0]] = 1'b0;
    for (int i = 0; i < len; i++) step(a, (glitchy && i == 1) ? (c0 ^ 4'h5) : c0);
    model_window(k, len, c0, glitchy);
  endtask

  task automatic frame(input logic [3:0] c3, input logic [3:0] c2, input logic [3:0] c1,
                       input logic [3:0] c0, input int len, input int g, input logic [3:0] gmask);
    window(3, len, c3, gmask[3]); idle(g);
    window(2, len, c2, gmask[2]); idle(g);
    window(1, len, c1, gmask[1]); idle(g);
    window(0, len, c0, gmask[0]); idle(g);
  endtask

  task automatic multi(input int k1, input int k2);
    logic [3:0] a;
    a = 4'hF; a[k1[1:0]] = 1'b0; a[k2[1:0]] = 1'b0;
    step(a, 4'($urandom));
    m_multi = 1'b1; m_next = 3; m_gap = 0;
  endtask

  task automatic err_clear();
    err_clr = 1'b1;
    step(4'hF, 4'($urandom));
    err_clr = 1'b0;
    m_order = 0; m_multi = 0; m_glitch = 0; m_width = 0; m_timeout = 0;
    model_gap(1);
  endtask

  task automatic checkpoint(input string tag);
    idle(3);
    chk({tag, ".pending"}, 32'(exp_q.size()), 32'd0);
    chk({tag, ".flags"},
        {27'd0, order_err, multi_err, glitch_err, width_err, timeout_err},
        {27'd0, m_order, m_multi, m_glitch, m_width, m_timeout});
    chk({tag, ".digits"}, {16'd0, digit3, digit2, digit1, digit0},
        {16'd0, m_dig[3], m_dig[2], m_dig[1], m_dig[0]});
    chk({tag, ".count"}, {24'd0, frame_count}, {24'd0, m_count});
  endtask

  // ---------------- frame monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (frame_valid) begin
        logic [24:0] e;
        checks++;
        assert (exp_q.size() != 0) else begin
          errors++;
          $error("FAIL frame.unexpected: observed=frame_valid expected=no frame");
        end
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("frame", {7'd0, digit3, digit2, digit1, digit0, scroll_step, frame_count},
              {7'd0, e});
        end
        last_scroll = scroll_step;
      end
      if (scroll_step) chk("scroll.needs_frame", {31'd0, frame_valid}, 32'd1);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; an_drv = 4'hF; ch = 4'h0; err_clr = 1'b0;
    model_reset();
    step(4'hF, 4'h0); step(4'hF, 4'h0); step(4'hF, 4'h0);
    chk("reset.digits", {16'd0, digit3, digit2, digit1, digit0}, 32'd0);
    chk("reset.count", {24'd0, frame_count}, 32'd0);
    chk("reset.pulses_flags",
        {25'd0, frame_valid, scroll_step, order_err, multi_err, glitch_err, width_err, timeout_err},
        32'd0);
    rst = 1'b0;

    // Clean frames, including a scroll step that wraps 0 -> 15.
    frame(4'h0, 4'h1, 4'h2, 4'h3, 2, 3, 4'b0000);
    checkpoint("frame1");
    chk("frame1.digits_const", {16'd0, digit3, digit2, digit1, digit0}, 32'h0123);
    chk("frame1.scroll", {31'd0, last_scroll}, 32'd0);
    frame(4'hF, 4'h0, 4'h1, 4'h2, 2, 3, 4'b0000);
    checkpoint("frame2");
    chk("frame2.digits_const", {16'd0, digit3, digit2, digit1, digit0}, 32'hF012);
    chk("frame2.scroll", {31'd0, last_scroll}, 32'd1);
    frame(4'h3, 4'h3, 4'h3, 4'h3, 2, 3, 4'b0000);
    checkpoint("frame3");
    chk("frame3.scroll", {31'd0, last_scroll}, 32'd0);

    // Skipped an2: order error, no commit; then a clean frame still commits.
    window(3, 2, 4'h5, 1'b0); idle(2); window(1, 2, 4'h6, 1'b0);
    checkpoint("order");
    frame(4'h7, 4'h8, 4'h9, 4'hA, 2, 2, 4'b0000);
    checkpoint("order_then_clean");

    // Two anodes low together.
    window(3, 2, 4'h1, 1'b0); idle(2); multi(2, 1);
    checkpoint("multi");

    // char changes inside a 3-cycle an3 window; the first code is kept.
    frame(4'hA, 4'hB, 4'hC, 4'hD, 3, 2, 4'b1000);
    checkpoint("glitch");
    chk("glitch.shadow_first", {28'd0, digit3}, 32'hA);

    // Window shorter than MIN_ON.
    window(3, 1, 4'h2, 1'b0);
    checkpoint("width");

    // Partial frame then a long idle gap.
    window(3, 2, 4'h4, 1'b0); idle(2); window(2, 2, 4'h4, 1'b0); idle(80);
    checkpoint("timeout");
    err_clear();
    checkpoint("err_clr");

    // Randomized operations.
    for (int it = 0; it < 30; it++) begin
      int r, len, g, k1, k2;
      r   = $urandom_range(0, 9);
      len = $urandom_range(2, 4);
      g   = $urandom_range(1, 4);
      case (r)
        5: frame(4'(m_dig[3] - 4'd1), 4'(m_dig[2] - 4'd1), 4'(m_dig[1] - 4'd1),
                 4'(m_dig[0] - 4'd1), len, g, 4'b0000);
        6: frame(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), len, g,
                 4'($urandom_range(1, 15)));
        7: begin window($urandom_range(0, 2), len, 4'($urandom), 1'b0); idle(g); end
        8: begin
          k1 = $urandom_range(0, 3);
          k2 = (k1 + 1 + $urandom_range(0, 2)) % 4;
          window(3, len, 4'($urandom), 1'b0); idle(g); multi(k1, k2); idle(g);
        end
        9: begin window(3, 1, 4'($urandom), 1'b0); idle(g); end
        default: frame(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), len, g, 4'b0000);
      endcase
      if (it % 5 == 4) err_clear();
      checkpoint($sformatf("rand%0d", it));
    end

    // Reset while inside the an1 window.
    frame(4'h9, 4'h8, 4'h7, 4'h6, 2, 2, 4'b0000);
    checkpoint("pre_reset");
    window(3, 2, 4'h1, 1'b0); idle(2); window(2, 2, 4'h2, 1'b0); idle(2);
    step(4'b1101, 4'h4); step(4'b1101, 4'h4);
    rst = 1'b1; #1;
    chk("rst_async.digits", {16'd0, digit3, digit2, digit1, digit0}, 32'd0);
    chk("rst_async.count", {24'd0, frame_count}, 32'd0);
    chk("rst_async.frame_valid", {31'd0, frame_valid}, 32'd0);
    model_reset();
    step(4'hF, 4'h0); step(4'hF, 4'h0);
    rst = 1'b0;
    // All digits equal reset value minus one: only first_frame keeps scroll low.
    frame(4'hF, 4'hF, 4'hF, 4'hF, 2, 2, 4'b0000);
    checkpoint("after_reset");
    chk("after_reset.scroll", {31'd0, last_scroll}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
